alien_move_pacer: RTL and testbench
===================================

# alien_move_pacer

Generates the one-cycle `mueva` move strobe that drives the alien-formation movement FSM. It counts video frames from the VGA timing block's `vsync`. The move period shortens as the number of live aliens falls, giving the classic speed-up. The block supports pause and single-step for debug, and sits between the VGA sync generator / alien-status logic (upstream) and the formation movement FSM (downstream).

## Interface
- `NUM_ALIENS`, default 55: fleet size; `alive` values above this saturate to it.
- `W_ALIVE`, default 6: width of `alive`.
- `CLK` input, 1 bit: system clock; all state updates on the rising edge.
- `RST` input, 1 bit: reset, asynchronous, active-low.
- `vsync` input, 1 bit: frame sync from VGA block, asynchronous to logic, active-high level.
- `alive` input, `W_ALIVE` bits: current live-alien count.
- `pause` input, 1 bit: level; freezes frame counting while high.
- `step` input, 1 bit: one-cycle pulse; honoured only in PAUSED.
- `mueva` output, 1 bit: move strobe, exactly one CLK cycle high.
- `period` output, 5 bits: currently latched frames-per-move.
- `move_cnt` output, 9 bits: moves issued since reset, wraps 511→0.

## Operation
- `vsync` passes through a 2-flop synchronizer plus 1 history flop; `frame_tick = sync2 & ~hist` (rising edge only).
- Period table on saturated `alive`:
  - ≥48 → 16
  - ≥32 → 12
  - ≥16 → 8
  - ≥8 → 4
  - ≥2 → 2
  - 1 → 1
  - 0 → no moves
- `period` is latched only on leaving ARM and on each issued `mueva`. Mid-interval `alive` changes affect the next interval only.
- The 5-bit frame counter `fcnt` increments on `frame_tick` in COUNT.
  - When `fcnt + 1 == period`: `mueva` is asserted, `fcnt` clears, `move_cnt` increments, and `period` re-latches.
- States:
  - ARM (reset state): wait for first `frame_tick`. Then latch `period`, clear `fcnt`, and go to COUNT (or STALL if `alive == 0`). This first tick is not counted.
  - COUNT: counting as above.
    - `pause == 1` → PAUSED, `fcnt` held.
    - Latched `alive` reads 0 at a re-latch → STALL.
  - PAUSED: no counting.
    - `step` pulse → `mueva` for one cycle, `move_cnt` increments, `fcnt` cleared, stay PAUSED.
    - `pause == 0` → COUNT, resuming from held `fcnt`.
  - STALL: `mueva` held 0. `alive != 0` (checked every cycle) → latch `period`, clear `fcnt`, go to COUNT.
    - `pause` overrides: go to PAUSED.
- Simultaneous events:
  - `frame_tick` in the same cycle `pause` rises: pause wins, tick discarded.
  - `step` outside PAUSED: ignored.
  - `step` and `pause` falling in the same cycle: step ignored, go to COUNT.
- `mueva` is never high on two consecutive cycles.

## Timing
- Reset (RST low, async) values:
  - `mueva` = 0
  - `period` = 16
  - `move_cnt` = 0
  - `fcnt` = 0
  - synchronizer and history flops = 0
  - state = ARM
- `vsync` first sampled high at rising edge k: `frame_tick` is valid in the cycle after edge k+1. Any resulting `mueva` registers high at edge k+2 and drops at edge k+3.
- Step latency: `step` high at edge k → `mueva` high at edge k+1 for one cycle.
- `mueva` is a full registered CLK cycle, so the downstream FSM's negative-edge sampling sees it exactly once.
- Release of RST takes effect on the next rising edge; no output changes before the first `frame_tick`.
- Asserting RST mid-interval discards `fcnt` and the pending move; the next `mueva` comes a full period after the first post-reset tick.

## Structure
- Shared package `invaders_pkg`:
  - state encoding (ARM, COUNT, PAUSED, STALL)
  - period-table thresholds and values
  - `NUM_ALIENS` default
  - `W_PERIOD` = 5
  - `W_MOVES` = 9
- Sub-module `vsync_edge_sync`: 2-flop synchronizer plus rising-edge detector, with outputs `frame_tick` and `sync_level`. It is reusable by other frame-paced blocks (bullet and explosion timers).
- Top level: the FSM, frame counter, period latch and move counter, in a single clocked process plus combinational next-state logic.

## Test plan
- Reset: RST low with `vsync` toggling → `mueva` = 0, `period` = 16, `move_cnt` = 0. After release, the first `vsync` edge produces no `mueva`.
- Full fleet: `alive` = 55, 40 `vsync` pulses → `mueva` after ticks 16 and 32 (counting from the ARM tick), `move_cnt` = 2. Each pulse is one cycle, 2 cycles after the synchronized edge.
- Speed-up: `alive` 55→1 mid-interval → current interval completes at 16. Then `period` = 1 and `mueva` fires on every subsequent frame.
- Pause/step: pause after 5 ticks of a 16 period, then 10 `vsync`, then two `step` pulses → exactly two `mueva`, `move_cnt` += 2. After unpause, the next `mueva` comes after 16 ticks (`fcnt` was cleared by `step`).
- Stall: `alive` = 0 at re-latch → no `mueva` for 50 frames. `alive` = 20 → `period` = 8, `mueva` after 8 ticks.
- Reset mid-interval: RST low at tick 10 of 16 → all outputs return to reset values; the next `mueva` comes 16 ticks after the post-reset ARM tick.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared definitions for the alien-fleet pacing logic: pacer states,
// move-period table and common widths.
package invaders_pkg;

    localparam int unsigned NUM_ALIENS_DEF = 55;
    localparam int unsigned W_PERIOD       = 5;
    localparam int unsigned W_MOVES        = 9;

    // Live-alien thresholds and the frames-per-move used at or above each one
    localparam int unsigned THR_P16 = 48;
    localparam int unsigned THR_P12 = 32;
    localparam int unsigned THR_P8  = 16;
    localparam int unsigned THR_P4  = 8;
    localparam int unsigned THR_P2  = 2;
    localparam int unsigned THR_P1  = 1;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        COUNT  = 2'd1,
        PAUSED = 2'd2,
        STALL  = 2'd3
    } pacer_state_t;

    // Frames per move for a (saturated) live count; 0 means the fleet is gone
    function automatic logic [W_PERIOD-1:0] period_for(input int unsigned n);
        if (n >= THR_P16)     return W_PERIOD'(16);
        else if (n >= THR_P12) return W_PERIOD'(12);
        else if (n >= THR_P8)  return W_PERIOD'(8);
        else if (n >= THR_P4)  return W_PERIOD'(4);
        else if (n >= THR_P2)  return W_PERIOD'(2);
        else if (n >= THR_P1)  return W_PERIOD'(1);
        else                   return '0;
    endfunction

endpackage

// File: rtl/alien_move_pacer_if.sv
// Signal bundle between the VGA sync / alien-status logic, the pacer and
// the formation movement FSM.
interface alien_move_pacer_if
    import invaders_pkg::*;
#(
    parameter int unsigned W_ALIVE = 6
);
    logic                vsync;
    logic [W_ALIVE-1:0]  alive;
    logic                pause;
    logic                step;
    logic                mueva;
    logic [W_PERIOD-1:0] period;
    logic [W_MOVES-1:0]  move_cnt;

    modport master (
        output vsync, alive, pause, step,
        input  mueva, period, move_cnt
    );

    modport slave (
        input  vsync, alive, pause, step,
        output mueva, period, move_cnt
    );
endinterface

// File: rtl/vsync_edge_sync.sv
// Two-flop synchronizer for the asynchronous vsync level plus a history
// flop giving a one-cycle pulse on each synchronized rising edge.
module vsync_edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic vsync,
    output logic frame_tick,
    output logic sync_level
);
    logic sync1, sync2, hist;

    // Synchronizer chain and edge-history register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= vsync;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign frame_tick = sync2 & ~hist;
    assign sync_level = sync2;

endmodule

// File: rtl/alien_move_pacer.sv
// Issues the one-cycle mueva strobe every 'period' frames, with the period
// picked from the live-alien count; supports pause, single-step and a
// stall when no aliens remain.
module alien_move_pacer
    import invaders_pkg::*;
#(
    parameter int unsigned NUM_ALIENS = NUM_ALIENS_DEF,
    parameter int unsigned W_ALIVE    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    alien_move_pacer_if.slave  bus
);
    pacer_state_t        state, state_n;
    logic [W_PERIOD-1:0] fcnt, fcnt_n;
    logic [W_PERIOD-1:0] period_q, period_n;
    logic [W_MOVES-1:0]  move_q, move_n;
    logic                mueva_q, mueva_n;

    logic                frame_tick;
    logic                sync_level_unused;
    logic [W_ALIVE-1:0]  alive_sat;
    logic                alive_zero;
    logic [W_PERIOD-1:0] table_period;

    vsync_edge_sync u_vsync_edge_sync (
        .CLK        (CLK),
        .RST        (RST),
        .vsync      (bus.vsync),
        .frame_tick (frame_tick),
        .sync_level (sync_level_unused)
    );

    // Clamp the live count to the fleet size and look up its move period
    always_comb begin
        alive_sat    = (32'(bus.alive) > NUM_ALIENS) ? W_ALIVE'(NUM_ALIENS) : bus.alive;
        alive_zero   = (alive_sat == '0);
        table_period = period_for(32'(alive_sat));
    end

    // State, frame counter, period latch, move counter and strobe registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ARM;
            fcnt     <= '0;
            period_q <= W_PERIOD'(16);
            move_q   <= '0;
            mueva_q  <= 1'b0;
        end else begin
            state    <= state_n;
            fcnt     <= fcnt_n;
            period_q <= period_n;
            move_q   <= move_n;
            mueva_q  <= mueva_n;
        end
    end

    // Next-state logic; period only re-latches when an interval starts
    always_comb begin
        state_n  = state;
        fcnt_n   = fcnt;
        period_n = period_q;
        move_n   = move_q;
        mueva_n  = 1'b0;
        case (state)
            ARM: begin
                if (frame_tick) begin
                    fcnt_n = '0;
                    if (alive_zero) begin
                        state_n = STALL;
                    end else begin
                        period_n = table_period;
                        state_n  = COUNT;
                    end
                end
            end
            COUNT: begin
                if (bus.pause) begin
                    state_n = PAUSED;
                end else if (frame_tick) begin
                    if ((fcnt + W_PERIOD'(1)) == period_q) begin
                        mueva_n = 1'b1;
                        fcnt_n  = '0;
                        move_n  = move_q + W_MOVES'(1);
                        if (alive_zero) state_n  = STALL;
                        else            period_n = table_period;
                    end else begin
                        fcnt_n = fcnt + W_PERIOD'(1);
                    end
                end
            end
            PAUSED: begin
                if (!bus.pause) begin
                    state_n = COUNT;
                end else if (bus.step && !mueva_q) begin
                    mueva_n = 1'b1;
                    move_n  = move_q + W_MOVES'(1);
                    fcnt_n  = '0;
                end
            end
            STALL: begin
                if (bus.pause) begin
                    state_n = PAUSED;
                end else if (!alive_zero) begin
                    period_n = table_period;
                    fcnt_n   = '0;
                    state_n  = COUNT;
                end
            end
            default: state_n = ARM;
        endcase
    end

    assign bus.mueva    = mueva_q;
    assign bus.period   = period_q;
    assign bus.move_cnt = move_q;

endmodule

// File: tb/tb_alien_move_pacer.sv
// Directed bench for alien_move_pacer: frames and steps push the expected
// move count into a queue, and a negedge monitor pops it on every mueva.
module tb_alien_move_pacer;
    import invaders_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alien_move_pacer_if #(.W_ALIVE(6)) bus ();

    alien_move_pacer #(.NUM_ALIENS(55), .W_ALIVE(6)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [8:0]  exp_q[$];
    int unsigned exp_cnt = 0;
    logic        mueva_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Scoreboard monitor: every strobe must be expected, carry the right count
    // and never follow another strobe directly
    always @(negedge clk) begin
        if (rst_n && bus.mueva === 1'b1) begin
            chk("mueva_back_to_back", 32'(mueva_prev), 32'd0);
            chk("mueva_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("move_cnt_at_mueva", 32'(bus.move_cnt), 32'(exp_q.pop_front()));
        end
        mueva_prev = bus.mueva;
    end

    // One vsync pulse (3 high, 3 low); strobe must land 3 negedges after the rise
    task automatic frame(input bit mv, input string tag);
        int pos = 0;
        if (mv) begin
            exp_cnt = (exp_cnt + 1) % 512;
            exp_q.push_back(9'(exp_cnt));
        end
        bus.vsync = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (pos == 0 && bus.mueva === 1'b1) pos = i;
            if (i == 3) bus.vsync = 1'b0;
        end
        chk(tag, 32'(pos), mv ? 32'd3 : 32'd0);
    endtask

    task automatic frames(input int n, input string tag);
        for (int i = 0; i < n; i++) frame(1'b0, tag);
    endtask

    task automatic do_step();
        exp_cnt = (exp_cnt + 1) % 512;
        exp_q.push_back(9'(exp_cnt));
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        chk("step_mueva_high", 32'(bus.mueva), 32'd1);
        @(negedge clk);
        chk("step_mueva_drop", 32'(bus.mueva), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bus.vsync = 1'b0;
        bus.alive = 6'd55;
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        @(negedge clk);

        // Reset held while vsync toggles
        frames(2, "reset_no_mueva");
        chk("reset_mueva", 32'(bus.mueva), 32'd0);
        chk("reset_period", 32'(bus.period), 32'd16);
        chk("reset_move_cnt", 32'(bus.move_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full fleet: ARM tick then 39 counted ticks -> moves at 16 and 32
        frame(1'b0, "arm_tick");
        frames(15, "full_wait1");
        frame(1'b1, "full_move1");
        frames(15, "full_wait2");
        frame(1'b1, "full_move2");
        frames(7, "full_tail");
        chk("full_move_cnt", 32'(bus.move_cnt), 32'd2);
        chk("full_period", 32'(bus.period), 32'd16);

        // Speed-up mid-interval: current interval still runs to 16
        bus.alive = 6'd1;
        frames(8, "speed_wait");
        frame(1'b1, "speed_move16");
        chk("speed_period", 32'(bus.period), 32'd1);
        for (int i = 0; i < 3; i++) frame(1'b1, "speed_every_frame");
        chk("speed_move_cnt", 32'(bus.move_cnt), 32'd6);

        // Pause and single-step
        bus.alive = 6'd63;
        frame(1'b1, "pause_prep_move");
        chk("saturated_period", 32'(bus.period), 32'd16);
        frames(5, "pause_pre");
        bus.pause = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frames(10, "paused_frames");
        do_step();
        do_step();
        chk("step_move_cnt", 32'(bus.move_cnt), 32'd9);
        bus.pause = 1'b0;
        @(negedge clk);
        frames(15, "unpause_wait");
        frame(1'b1, "unpause_move");

        // Stall when the fleet is gone at re-latch
        bus.alive = 6'd0;
        frames(15, "stall_prep");
        frame(1'b1, "stall_entry_move");
        frames(50, "stall_frames");
        bus.alive = 6'd20;
        @(negedge clk);
        @(negedge clk);
        chk("stall_exit_period", 32'(bus.period), 32'd8);
        frames(7, "stall_exit_wait");
        bus.alive = 6'd55;
        frame(1'b1, "stall_exit_move");
        chk("relatch_period", 32'(bus.period), 32'd16);
        chk("stall_move_cnt", 32'(bus.move_cnt), 32'd12);

        // Reset mid-interval discards the pending move
        frames(10, "pre_reset");
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_mueva", 32'(bus.mueva), 32'd0);
        chk("midrst_period", 32'(bus.period), 32'd16);
        chk("midrst_move_cnt", 32'(bus.move_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(1'b0, "post_reset_arm");
        frames(15, "post_reset_wait");
        frame(1'b1, "post_reset_move");
        chk("post_reset_move_cnt", 32'(bus.move_cnt), 32'd1);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
